// File: rtl/led_pkg.sv
// Shared constants and scan state encoding for the LED scan controller.
package led_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  // One-hot anode pattern for a given row index.
  function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [1:0] row);
    logic [NUM_ROWS-1:0] v;
    v      = '0;
    v[row] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Frame-load and LED-drive signals of the scan controller, bundled for the port list.
interface led_scan_ctrl_if;

  logic        en;
  logic [15:0] ledbits;
  logic [3:0]  brightness;
  logic        load;
  logic [3:0]  aled;
  logic [3:0]  kled_tri;
  logic        frame_sync;
  logic        pending;

  modport master (
    output en, ledbits, brightness, load,
    input  aled, kled_tri, frame_sync, pending
  );

  modport slave (
    input  en, ledbits, brightness, load,
    output aled, kled_tri, frame_sync, pending
  );

endinterface

// File: rtl/led_dwell_timer.sv
// Blank and dwell counters for the scan FSM. Counters only ever return to zero
// on a phase change or a clear, never by rolling over.
module led_dwell_timer
  import led_pkg::*;
#(
  parameter int BLANK_CYC  = 64,
  parameter int DWELL_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  scan_state_t           state,
  output logic                  phase_done,
  output logic [DWELL_LOG2-1:0] dwell_next
);

  localparam int BLANK_W = $clog2(BLANK_CYC + 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYC - 1);

  logic [BLANK_W-1:0]    blank_cnt;
  logic [BLANK_W-1:0]    blank_next;
  logic [DWELL_LOG2-1:0] dwell_cnt;

  // Terminal count of whichever phase the FSM is currently in.
  always_comb begin
    phase_done = 1'b0;
    if (state == BLANK) phase_done = (blank_cnt == BLANK_LAST);
    else                phase_done = (&dwell_cnt);
  end

  // Next counter values; the idle counter and a finished phase both return to zero.
  always_comb begin
    blank_next = '0;
    dwell_next = '0;
    if (!clear) begin
      if (state == BLANK) begin
        if (!phase_done) blank_next = blank_cnt + 1'b1;
      end else begin
        if (!phase_done) dwell_next = dwell_cnt + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt <= '0;
      dwell_cnt <= '0;
    end else begin
      blank_cnt <= blank_next;
      dwell_cnt <= dwell_next;
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// 4x4 LED matrix scanner: one anode row at a time with a blanking gap before
// each row, PWM on the cathodes, and a double-buffered frame that only swaps
// at the end of row 3 so a displayed frame is never mixed.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int BLANK_CYC  = 64,
  parameter int DWELL_LOG2 = 12
) (
  input logic            clk,
  input logic            rst,
  led_scan_ctrl_if.slave bus
);

  localparam int ROW_W = $clog2(NUM_ROWS);

  scan_state_t           state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [15:0]           active_bits_q, active_bits_d;
  logic [3:0]            active_bright_q, active_bright_d;
  logic [15:0]           shadow_bits_q, shadow_bits_d;
  logic [3:0]            shadow_bright_q, shadow_bright_d;
  logic                  pending_q, pending_d;
  logic                  frame_sync_q, frame_sync_d;
  logic [NUM_ROWS-1:0]   aled_q, aled_d;
  logic [NUM_COLS-1:0]   kled_q, kled_d;
  logic                  phase_done;
  logic                  boundary;
  logic                  duty_on;
  logic                  scan_clear;
  logic [DWELL_LOG2-1:0] dwell_next;

  assign scan_clear = !bus.en;

  led_dwell_timer #(
    .BLANK_CYC  (BLANK_CYC),
    .DWELL_LOG2 (DWELL_LOG2)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (scan_clear),
    .state      (state_q),
    .phase_done (phase_done),
    .dwell_next (dwell_next)
  );

  // Scan FSM: blank gap, then row dwell, then on to the next row; en low parks it at row 0.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    boundary = 1'b0;
    if (!bus.en) begin
      state_d = BLANK;
      row_d   = '0;
    end else if (phase_done) begin
      if (state_q == BLANK) begin
        state_d = ON;
      end else begin
        state_d  = BLANK;
        row_d    = row_q + 1'b1;
        boundary = (row_q == ROW_W'(NUM_ROWS - 1));
      end
    end
  end

  // Frame buffers: loads fill the shadow, the frame boundary moves it to active.
  always_comb begin
    shadow_bits_d   = shadow_bits_q;
    shadow_bright_d = shadow_bright_q;
    active_bits_d   = active_bits_q;
    active_bright_d = active_bright_q;
    pending_d       = pending_q;
    frame_sync_d    = 1'b0;
    if (boundary && pending_q) begin
      active_bits_d   = shadow_bits_q;
      active_bright_d = shadow_bright_q;
      frame_sync_d    = 1'b1;
      pending_d       = 1'b0;
    end
    if (bus.load) begin
      shadow_bits_d   = bus.ledbits;
      shadow_bright_d = bus.brightness;
      pending_d       = 1'b1;
    end
  end

  // Drive values for the coming cycle, so the output flops line up with the FSM state.
  always_comb begin
    aled_d  = '0;
    kled_d  = '0;
    duty_on = (dwell_next[DWELL_LOG2-1 -: 4] < active_bright_d);
    if (state_d == ON) begin
      aled_d = row_onehot(row_d);
      for (int c = 0; c < NUM_COLS; c++) begin
        kled_d[c] = active_bits_d[{row_d, 2'(c)}] & duty_on;
      end
    end
  end

  // State, buffer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= BLANK;
      row_q           <= '0;
      active_bits_q   <= '0;
      active_bright_q <= 4'hF;
      shadow_bits_q   <= '0;
      shadow_bright_q <= 4'hF;
      pending_q       <= 1'b0;
      frame_sync_q    <= 1'b0;
      aled_q          <= '0;
      kled_q          <= '0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      active_bits_q   <= active_bits_d;
      active_bright_q <= active_bright_d;
      shadow_bits_q   <= shadow_bits_d;
      shadow_bright_q <= shadow_bright_d;
      pending_q       <= pending_d;
      frame_sync_q    <= frame_sync_d;
      aled_q          <= aled_d;
      kled_q          <= kled_d;
    end
  end

  assign bus.aled       = aled_q;
  assign bus.kled_tri   = kled_q;
  assign bus.frame_sync = frame_sync_q;
  assign bus.pending    = pending_q;

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 The block SHALL have parameter BLANK_CYC, default 64, giving the all-off cycles before each row window (minimum 1).
REQ-002 The block SHALL have parameter DWELL_LOG2, default 12, where the row ON window is 2**DWELL_LOG2 cycles (minimum 4).
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock (48 MHz HFOSC domain)
- rst  in  1  synchronous, active-high reset
- en  in  1  scan enable
- ledbits  in  16  frame data; bit 4*row+col = LED (row,col)
- brightness  in  4  global duty, 0 = dark, 15 = 15/16
- load  in  1  one-cycle strobe; captures ledbits and brightness into the shadow
- aled  out  4  anode drive, one-hot active row
- kled_tri  out  4  cathode enables; bit c = 1 lights (active row, c)
- frame_sync  out  1  one-cycle pulse on the shadow-to-active transfer
- pending  out  1  shadow holds data not yet displayed

Function
REQ-004 The FSM SHALL have states BLANK and ON, plus a 2-bit row index cycling 0,1,2,3,0.
- BLANK: aled = 0 and kled_tri = 0 for exactly BLANK_CYC cycles, then ON.
- ON: aled = one-hot(row) for exactly 2**DWELL_LOG2 cycles, then BLANK with row+1 mod 4.
REQ-005 All outputs SHALL be registered and SHALL reflect the FSM state of the same cycle. No output may be driven combinationally from an input.
REQ-006 In ON, kled_tri[c] SHALL equal active[4*row+c] AND (dwell_cnt[DWELL_LOG2-1 -: 4] < active_brightness).
REQ-007 Brightness 0 SHALL keep every cathode off. Brightness b SHALL light each set LED for b*2**(DWELL_LOG2-4) cycles at the start of each ON window.
REQ-008 A load pulse SHALL copy ledbits and brightness into the shadow registers and set pending. If several loads arrive before a frame boundary, the last one wins.
REQ-009 The frame boundary SHALL be the last ON cycle of row 3. If pending=1 on that cycle:
- on the next cycle, active data and brightness SHALL take the shadow value;
- on that same next cycle, frame_sync SHALL pulse for one cycle and pending SHALL clear.
REQ-010 If pending=0 at the frame boundary, there SHALL be no transfer and no frame_sync pulse.
REQ-011 If load coincides with the boundary cycle:
- the transfer SHALL use the pre-load shadow;
- the new data SHALL land in the shadow;
- pending SHALL remain 1.
REQ-012 While en=0:
- the FSM SHALL be forced to BLANK, row 0, counters cleared;
- outputs SHALL be 0 from the next cycle;
- load and pending SHALL continue to operate.
REQ-013 On an en 0->1 transition, scanning SHALL restart with the full BLANK_CYC of row 0.
REQ-014 Counters SHALL wrap only by FSM transition and never by overflow. The blank counter width SHALL be clog2(BLANK_CYC+1).
REQ-015 A new frame SHALL never be applied mid-frame. The rows of one displayed frame SHALL always come from a single active snapshot.

Reset
REQ-016 While rst=1 on a clock edge, the block SHALL set:
- aled = 0, kled_tri = 0, frame_sync = 0, pending = 0;
- active data and shadow data = 0;
- active brightness and shadow brightness = 4'hF;
- FSM = BLANK, row 0, counters 0.
REQ-017 Reset mid-operation SHALL discard the shadow and the current frame. After rst falls, scanning SHALL start from BLANK row 0, provided en=1.

Structure
REQ-018 Shared package led_pkg SHALL hold NUM_ROWS=4, NUM_COLS=4 and the scan state encoding (BLANK, ON).
REQ-019 The block SHALL use one sub-module, led_dwell_timer. It SHALL own the blank and dwell counters and assert phase_done on the terminal count. The FSM, buffers and PWM compare SHALL stay in led_scan_ctrl.

Verification
Bench parameters: BLANK_CYC=4 and DWELL_LOG2=4, giving a row period of 20 cycles and a frame of 80 cycles.
REQ-020 Reset, en=1, no load -> aled sequence 0,1,2,4,8 repeating, with 4 blank cycles then 16 one-hot cycles; kled_tri stays 0 (active data 0).
REQ-021 Load ledbits=16'h8421, brightness=15 -> after the next boundary: frame_sync pulses once; row r lights only col r for 15 of its 16 ON cycles; pending drops 1->0.
REQ-022 Brightness sweep with ledbits=16'hFFFF, b=0, 1, 8 -> lit cycles per row window = 0, 1, 8.
REQ-023 Load 16'h000F and load 16'h00F0 both before a boundary, then load 16'h0F00 on the boundary cycle -> displayed frame is 16'h00F0; pending stays 1; the next boundary shows 16'h0F00.
REQ-024 Drop en in the middle of row 2 -> outputs are 0 on the next cycle. Raise en -> 4 blank cycles, then aled = 4'b0001. Assert rst mid-frame -> reset values per REQ-016.
